axi_rd_arbiter: RTL

- Shares one AXI4 read channel (AR + R) between the instruction-fetch and data-load requesters of the CPU core.
- Accepts burst read requests on the core-side req/addr_ok handshake, issues one AR at a time, and steers returned R beats to the granted requester.
- Sits between hhhh_mips and the AXI master port, in the read path that cpu_axi_interface currently occupies. The write channels are out of scope.
- Data has priority over instruction fetch; a streak counter prevents instruction starvation.

---
 rtl/axi_rd_arbiter_pkg.sv | 27 ++
 rtl/axi_rd_arbiter_if.sv | 57 +++++
 rtl/axi_rd_arbiter_rd_grant_sel.sv | 44 ++++
 rtl/axi_rd_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_rd_arbiter_pkg                                     |
// | Description : Shared AXI constants, FSM state and owner encodings    |
// |               for the instruction/data read-channel arbiter.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package axi_rd_arbiter_pkg;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [2:0] SIZE_4B      = 3'b010;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [3:0] CACHE_NORMAL = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_rd_arbiter_if                                      |
// | Description : Core-side request/beat signals plus AXI AR/R channel   |
// |               bundled for the read arbiter. master = arbiter view,   |
// |               slave = environment (core + AXI slave) view.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32
);
  // core side
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [3:0]        inst_burst;
  logic              inst_addr_ok;
  logic              inst_beat_valid;
  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_burst;
  logic              data_addr_ok;
  logic              data_beat_valid;
  logic [31:0]       beat_rdata;
  logic              beat_last;
  logic              beat_err;
  logic              proto_err;
  // AXI read address / data
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    input  inst_req, inst_addr, inst_burst, data_req, data_addr, data_burst,
    input  arready, rdata, rresp, rlast, rvalid,
    output inst_addr_ok, inst_beat_valid, data_addr_ok, data_beat_valid,
    output beat_rdata, beat_last, beat_err, proto_err,
    output araddr, arlen, arsize, arburst, arcache, arvalid, rready
  );

  modport slave (
    output inst_req, inst_addr, inst_burst, data_req, data_addr, data_burst,
    output arready, rdata, rresp, rlast, rvalid,
    input  inst_addr_ok, inst_beat_valid, data_addr_ok, data_beat_valid,
    input  beat_rdata, beat_last, beat_err, proto_err,
    input  araddr, arlen, arsize, arburst, arcache, arvalid, rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter_rd_grant_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rd_grant_sel                                           |
// | Description : Data-over-inst priority with a saturating data streak  |
// |               so a pending instruction fetch cannot starve.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rd_grant_sel
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic       inst_req,
  input  logic       data_req,
  input  logic [3:0] streak,
  output logic       grant_valid,
  output owner_e     grant_owner,
  output logic [3:0] streak_next
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  // priority pick and the streak value to adopt if the grant is taken
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_INST;
    streak_next = streak;
    if (data_req && !(inst_req && (streak == STREAK_MAX))) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DATA;
      if (inst_req) begin
        streak_next = (streak == STREAK_MAX) ? streak : streak + 4'd1;
      end else begin
        streak_next = 4'd0;
      end
    end else if (inst_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_INST;
      streak_next = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_rd_arbiter                                         |
// | Description : Shares one AXI4 read channel between instruction fetch |
// |               and data load. One outstanding burst; R beats steered  |
// |               to the owner; rlast cross-checked against arlen.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_rd_arbiter_if.master     bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [3:0]        arcache_q, arcache_d;
  logic              arvalid_q, arvalid_d;
  logic              inst_addr_ok_q, inst_addr_ok_d;
  logic              data_addr_ok_q, data_addr_ok_d;
  logic              proto_err_q, proto_err_d;

  logic              grant_valid;
  owner_e            grant_owner;
  logic [3:0]        streak_next;

  rd_grant_sel #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant_sel (
    .inst_req    (bus.inst_req),
    .data_req    (bus.data_req),
    .streak      (streak_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner),
    .streak_next (streak_next)
  );

  // next-state: grant in IDLE, AR handshake in ADDR, beat tracking in RESP
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    beat_cnt_d     = beat_cnt_q;
    streak_d       = streak_q;
    araddr_d       = araddr_q;
    arlen_d        = arlen_q;
    arsize_d       = arsize_q;
    arburst_d      = arburst_q;
    arcache_d      = arcache_q;
    arvalid_d      = arvalid_q;
    inst_addr_ok_d = 1'b0;
    data_addr_ok_d = 1'b0;
    proto_err_d    = proto_err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d    = ADDR;
          owner_d    = grant_owner;
          streak_d   = streak_next;
          beat_cnt_d = 4'd0;
          araddr_d   = (grant_owner == OWN_DATA) ? bus.data_addr : bus.inst_addr;
          arlen_d    = {4'b0, (grant_owner == OWN_DATA) ? bus.data_burst : bus.inst_burst};
          arsize_d   = SIZE_4B;
          arburst_d  = BURST_INCR;
          arcache_d  = CACHE_NORMAL;
          arvalid_d  = 1'b1;
        end
      end
      ADDR: begin
        if (arvalid_q && bus.arready) begin
          arvalid_d      = 1'b0;
          inst_addr_ok_d = (owner_q == OWN_INST);
          data_addr_ok_d = (owner_q == OWN_DATA);
          state_d        = RESP;
        end
      end
      RESP: begin
        if (bus.rvalid) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          // rlast must coincide exactly with the arlen-th beat
          if (bus.rlast != ({4'b0, beat_cnt_q} == arlen_q)) begin
            proto_err_d = 1'b1;
          end
          if (bus.rlast) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and AR register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_INST;
      beat_cnt_q     <= 4'd0;
      streak_q       <= 4'd0;
      araddr_q       <= '0;
      arlen_q        <= 8'd0;
      arsize_q       <= 3'd0;
      arburst_q      <= 2'd0;
      arcache_q      <= 4'd0;
      arvalid_q      <= 1'b0;
      inst_addr_ok_q <= 1'b0;
      data_addr_ok_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      beat_cnt_q     <= beat_cnt_d;
      streak_q       <= streak_d;
      araddr_q       <= araddr_d;
      arlen_q        <= arlen_d;
      arsize_q       <= arsize_d;
      arburst_q      <= arburst_d;
      arcache_q      <= arcache_d;
      arvalid_q      <= arvalid_d;
      inst_addr_ok_q <= inst_addr_ok_d;
      data_addr_ok_q <= data_addr_ok_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign bus.araddr          = araddr_q;
  assign bus.arlen           = arlen_q;
  assign bus.arsize          = arsize_q;
  assign bus.arburst         = arburst_q;
  assign bus.arcache         = arcache_q;
  assign bus.arvalid         = arvalid_q;
  assign bus.rready          = (state_q == RESP);
  assign bus.inst_addr_ok    = inst_addr_ok_q;
  assign bus.data_addr_ok    = data_addr_ok_q;
  assign bus.proto_err       = proto_err_q;
  assign bus.inst_beat_valid = (state_q == RESP) && bus.rvalid && (owner_q == OWN_INST);
  assign bus.data_beat_valid = (state_q == RESP) && bus.rvalid && (owner_q == OWN_DATA);
  assign bus.beat_rdata      = bus.rdata;
  assign bus.beat_last       = bus.rlast;
  assign bus.beat_err        = (bus.rresp != RESP_OKAY);

endmodule
`default_nettype wire
